mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates one single-port unified memory between the RISC-V instruction-fetch port and the load/store port.
- Replaces separate imem/dmem when the core is built with a shared memory.
- Sequences each access through an issue/wait/response FSM with configurable read latency.
- Applies round-robin fairness when both ports request in the same cycle.

Parameters:
LATENCY, 1, memory cycles from issue (m_en=1) to valid m_rdata; legal range 1..4.
DATA_FIRST, 1, on the first contention after reset: 1 = data port wins, 0 = fetch port wins.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
i_req  input  1  fetch request; held with i_addr stable until i_gnt
i_addr  input  32  fetch byte address
i_gnt  output  1  one-cycle pulse: fetch access issued this cycle
i_rvalid  output  1  one-cycle pulse: i_rdata valid
i_rdata  output  32  fetch data; 0 when i_rvalid=0
d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data byte address
d_wdata  input  32  store data
d_gnt  output  1  one-cycle pulse: data access issued this cycle
d_rvalid  output  1  one-cycle pulse: load data valid, or store acknowledged
d_rdata  output  32  load data; 0 when d_rvalid=0 or for stores
m_en  output  1  memory access strobe, asserted for exactly one cycle per access
m_we  output  1  memory write enable; qualified by m_en
m_addr  output  32  memory address
m_wdata  output  32  memory write data
m_rdata  input  32  memory read data, valid LATENCY cycles after m_en
busy  output  1  1 while an access is outstanding (state WAIT)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE, the wait counter clears, and the round-robin pointer loads from DATA_FIRST.
  - All outputs are 0.
  - An access outstanding when reset asserts is abandoned. No rvalid is ever produced for it.
- FSM states are IDLE and WAIT. Only one access is in flight at a time; there is no pipelining.
- IDLE with no request:
  - m_en, m_we, m_addr, m_wdata, the gnt outputs and busy are all 0.
- IDLE with at least one request (issue cycle):
  - Winner selection is combinational:
    - A single requester wins.
    - If both request, the port not granted last wins.
    - Before any grant since reset, DATA_FIRST decides.
  - m_en=1. m_addr and m_wdata come from the winner. m_we = d_we for the data port, 0 for fetch.
  - The winner's gnt=1 in the same cycle.
  - Next state is WAIT. Count loads LATENCY. The winner is recorded as both owner and last-granted.
- WAIT:
  - m_en=0 and busy=1.
  - Count decrements each cycle.
  - Response cycle: the cycle where count==1 before the decrement, i.e. issue cycle + LATENCY.
  - In the response cycle the owner's rvalid=1, and its rdata = m_rdata (data port, loads only).
  - Next state is IDLE.
- Throughput is one access per LATENCY+1 cycles.
  - A request held continuously is re-granted in the cycle after rvalid.
- Requests during WAIT remain pending and are evaluated in the next IDLE cycle.
  - Dropping a request before grant is legal; it has no side effects.
- Both requesting continuously gives strict alternation of grants.
- Stores produce d_rvalid as a write acknowledge, with d_rdata=0.
- No address checking is performed; m_addr passes all 32 bits.
- Outputs i_gnt and d_gnt are never both 1. i_rvalid and d_rvalid are never both 1.

Test Plan:
- After reset, LATENCY=1: i_req=1, i_addr=0x00000000 with memory word 0x00500093 -> i_gnt, m_en, m_addr=0 in cycle 0; i_rvalid=1, i_rdata=0x00500093 in cycle 1; regrant in cycle 2.
- DATA_FIRST=1, both requesting continuously with i_addr=0x4, d_addr=0x100 load -> grant order d,i,d,i; m_addr sequence 0x100,0x4,0x100,0x4, spaced LATENCY+1 cycles.
- Store d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, then a load from 0x20 -> first access: m_we=1 and d_rvalid with d_rdata=0; second access returns d_rdata=0xDEADBEEF.
- LATENCY=3 load: d_rvalid exactly 3 cycles after d_gnt; busy high for 3 cycles; an i_req arriving during WAIT is granted in the cycle after d_rvalid.
- Assert rst in WAIT, one cycle before the response -> no rvalid ever appears; all outputs 0; the first post-reset contention follows DATA_FIRST.
- Idle bus with i_req=d_req=0 for 10 cycles -> m_en=0, busy=0, and no gnt or rvalid pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared instruction/data memory arbiter: one access in flight, issue/wait FSM
// with fixed read latency and round-robin selection on contention.
module mem_arbiter #(
    parameter int unsigned LATENCY    = 1,
    parameter bit          DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state, state_nxt;
    logic [2:0] count, count_nxt;
    logic       prefer_d, prefer_d_nxt;   // data port wins the next contention
    logic       owner_d, owner_d_nxt;
    logic       owner_we, owner_we_nxt;
    logic       pick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            prefer_d <= DATA_FIRST;
            owner_d  <= 1'b0;
            owner_we <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            prefer_d <= prefer_d_nxt;
            owner_d  <= owner_d_nxt;
            owner_we <= owner_we_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        prefer_d_nxt = prefer_d;
        owner_d_nxt  = owner_d;
        owner_we_nxt = owner_we;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        m_en         = 1'b0;
        m_we         = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        busy         = 1'b0;
        pick_d       = d_req && (!i_req || prefer_d);

        unique case (state)
            IDLE: begin
                // rst gates the issue path so outputs stay 0 while reset is held
                if (!rst && (i_req || d_req)) begin
                    m_en = 1'b1;
                    if (pick_d) begin
                        d_gnt   = 1'b1;
                        m_we    = d_we;
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                    end else begin
                        i_gnt  = 1'b1;
                        m_addr = i_addr;
                    end
                    state_nxt    = WAIT;
                    count_nxt    = 3'(LATENCY);
                    prefer_d_nxt = !pick_d;
                    owner_d_nxt  = pick_d;
                    owner_we_nxt = pick_d && d_we;
                end
            end
            WAIT: begin
                busy      = 1'b1;
                count_nxt = count - 3'd1;
                if (count == 3'd1) begin
                    state_nxt = IDLE;
                    if (owner_d) begin
                        d_rvalid = 1'b1;
                        d_rdata  = owner_we ? '0 : m_rdata;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rdata  = m_rdata;
                    end
                end
            end
        endcase
    end

endmodule
